// File: rtl/low_pass_ctrl.sv
// rtl/low_pass_ctrl.sv - frame sequencer feeding and draining the low_pass filter
//
// Purpose:
//   Loads one grayscale frame (WIDTH rows x DEPTH pixels) from a valid/ready
//   pixel stream into the filter with lp_en, waits a settle interval, then
//   runs the filter with lp_en_proc and emits each filtered pixel with its
//   raster index. All outputs are registered.
//
// Optional feature macro: LP_CTRL_TIMEOUT_EN
//   Adds o_err and a load-stall counter. If TIMEOUT_CYCLES consecutive LOAD
//   cycles pass without an accepted pixel, the frame is abandoned: o_err and
//   o_lp_rst pulse for one cycle and the block returns to IDLE with no done.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst            synchronous active-high reset
//   i_start          one-cycle frame request, honoured only in IDLE
//   i_pix_in_valid   source pixel valid
//   i_pix_in         source pixel
//   o_pix_in_ready   pixel accepted this cycle when valid
//   o_lp_rst         filter reset
//   o_lp_data        filter image_input
//   o_lp_en          filter enable (load strobe)
//   o_lp_en_proc     filter enable_process
//   i_lp_out         filter image_output
//   o_pix_out_valid  filtered pixel valid
//   o_pix_out        filtered pixel
//   o_pix_out_index  raster index of o_pix_out
//   o_busy           high whenever not IDLE
//   o_done           one-cycle pulse with the last output pixel
//   o_err            load timeout pulse (LP_CTRL_TIMEOUT_EN only)

module low_pass_ctrl #(
  parameter int DEPTH          = 410,
  parameter int WIDTH          = 361,
  parameter int SETTLE_CYCLES  = 2,
  parameter int CNT_W          = 18,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_pix_in_valid,
  input  logic [7:0]       i_pix_in,
  output logic             o_pix_in_ready,
  output logic             o_lp_rst,
  output logic [7:0]       o_lp_data,
  output logic             o_lp_en,
  output logic             o_lp_en_proc,
  input  logic [7:0]       i_lp_out,
  output logic             o_pix_out_valid,
  output logic [7:0]       o_pix_out,
  output logic [CNT_W-1:0] o_pix_out_index,
  output logic             o_busy,
  output logic             o_done
`ifdef LP_CTRL_TIMEOUT_EN
  ,
  output logic             o_err
`endif
);

  localparam int FRAME = WIDTH * DEPTH;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME - 1);

  // Parameter legality, caught at elaboration.
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("low_pass_ctrl: SETTLE_CYCLES out of range 1..15");
  end
  if ((longint'(1) << CNT_W) <= longint'(FRAME)) begin : g_bad_cnt_w
    $error("low_pass_ctrl: CNT_W too small for WIDTH*DEPTH");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("low_pass_ctrl: TIMEOUT_CYCLES must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_LOAD   = 3'd2,
    S_SETTLE = 3'd3,
    S_PROC   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_load_cnt;
  logic [CNT_W-1:0] r_proc_cnt;
  logic [3:0]       r_settle_cnt;
  logic             w_accept;
  logic             w_timeout;
  logic             w_lp_rst;

  logic             r_pix_in_ready;
  logic             r_lp_rst;
  logic [7:0]       r_lp_data;
  logic             r_lp_en;
  logic             r_lp_en_proc;
  logic             r_pix_out_valid;
  logic [7:0]       r_pix_out;
  logic [CNT_W-1:0] r_pix_out_index;
  logic             r_busy;
  logic             r_done;

  assign w_accept = (r_state == S_LOAD) && i_pix_in_valid;

`ifdef LP_CTRL_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] r_stall_cnt;
  logic               r_err;

  // Fires on the edge that would take the stall count to TIMEOUT_CYCLES.
  assign w_timeout = (r_state == S_LOAD) && !i_pix_in_valid &&
                     (r_stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (r_state != S_LOAD || w_accept) begin
        r_stall_cnt <= '0;
      end else if (!w_timeout) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign o_err = r_err;
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:   if (i_start) w_next_state = S_CLR;
      S_CLR:    w_next_state = S_LOAD;
      S_LOAD: begin
        if (w_accept && r_load_cnt == LAST_IDX) begin
          w_next_state = S_SETTLE;
        end else if (w_timeout) begin
          w_next_state = S_IDLE;
        end
      end
      // The first SETTLE cycle still carries the final registered lp_en
      // pulse, so stay one extra cycle to leave SETTLE_CYCLES quiet cycles.
      S_SETTLE: if (r_settle_cnt == 4'(SETTLE_CYCLES)) w_next_state = S_PROC;
      S_PROC:   if (r_proc_cnt == LAST_IDX) w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
    w_lp_rst = (w_next_state == S_CLR) || w_timeout;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_load_cnt      <= '0;
      r_proc_cnt      <= '0;
      r_settle_cnt    <= '0;
      r_pix_in_ready  <= 1'b0;
      r_lp_rst        <= 1'b1;
      r_lp_data       <= '0;
      r_lp_en         <= 1'b0;
      r_lp_en_proc    <= 1'b0;
      r_pix_out_valid <= 1'b0;
      r_pix_out       <= '0;
      r_pix_out_index <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state <= w_next_state;

      if (w_next_state == S_CLR) begin
        r_load_cnt <= '0;
        r_proc_cnt <= '0;
      end else begin
        if (w_accept && r_load_cnt != LAST_IDX) r_load_cnt <= r_load_cnt + 1'b1;
        if (r_state == S_PROC && r_proc_cnt != LAST_IDX) r_proc_cnt <= r_proc_cnt + 1'b1;
      end

      r_settle_cnt <= (r_state == S_SETTLE) ? r_settle_cnt + 1'b1 : 4'd0;

      // Outputs are decoded from the next state so they line up with it.
      r_pix_in_ready <= (w_next_state == S_LOAD);
      r_lp_rst       <= w_lp_rst;
      r_lp_en        <= w_accept;
      if (w_accept) r_lp_data <= i_pix_in;
      r_lp_en_proc   <= (w_next_state == S_PROC);
      r_busy         <= (w_next_state != S_IDLE);
      r_done         <= (w_next_state == S_DONE);

      // Filter output for an lp_en_proc cycle is captured at its closing edge.
      r_pix_out_valid <= (r_state == S_PROC);
      if (r_state == S_PROC) begin
        r_pix_out       <= i_lp_out;
        r_pix_out_index <= r_proc_cnt;
      end
    end
  end

  assign o_pix_in_ready  = r_pix_in_ready;
  assign o_lp_rst        = r_lp_rst;
  assign o_lp_data       = r_lp_data;
  assign o_lp_en         = r_lp_en;
  assign o_lp_en_proc    = r_lp_en_proc;
  assign o_pix_out_valid = r_pix_out_valid;
  assign o_pix_out       = r_pix_out;
  assign o_pix_out_index = r_pix_out_index;
  assign o_busy          = r_busy;
  assign o_done          = r_done;

endmodule

// File: doc/low_pass_ctrl.md
Name: low_pass_ctrl

Overview:
- Frame sequencer for the low_pass filter datapath.
- Accepts one grayscale frame as a valid/ready pixel stream and loads it into the filter using `enable`.
- Waits a fixed settle interval, then drives `enable_process` and captures every filtered pixel with its index.
- Sits between the pixel source (file reader or DMA) and the image sink. Replaces bench-driven sequencing of `en`/`en_proc`.

Parameters:
- DEPTH, 410, image width in pixels.
- WIDTH, 361, image length in rows.
- SETTLE_CYCLES, 2, idle cycles between last load and first process cycle; legal range 1..15.
- CNT_W, 18, pixel counter width; must satisfy 2^CNT_W > WIDTH*DEPTH.
- TIMEOUT_CYCLES, 1024, load-stall limit; used only with LP_CTRL_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to process one frame; honoured only in IDLE.
- pix_in_valid  in  1  source pixel valid.
- pix_in  in  8  source pixel.
- pix_in_ready  out  1  controller accepts pixel this cycle.
- lp_rst  out  1  to filter rst.
- lp_data  out  8  to filter image_input.
- lp_en  out  1  to filter enable.
- lp_en_proc  out  1  to filter enable_process.
- lp_out  in  8  from filter image_output.
- pix_out_valid  out  1  filtered pixel valid.
- pix_out  out  8  filtered pixel.
- pix_out_index  out  CNT_W  raster index of pix_out, 0..FRAME-1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame completion.
- err  out  1  present only with LP_CTRL_TIMEOUT_EN.

Behaviour:
- FRAME = WIDTH*DEPTH, computed at elaboration.
- All outputs are registered.
- Reset values: lp_rst=1; all other outputs 0; state IDLE; counters 0.
- rst asserted in any state returns the block to IDLE on the next edge. There is no partial-frame resume.
- IDLE: lp_rst=0.
  - start=1 -> CLR.
  - start is ignored in all other states.
- CLR: lp_rst=1 for exactly one cycle; load_cnt cleared -> LOAD.
- LOAD: pix_in_ready=1.
  - On each cycle with pix_in_valid=1: next edge sets lp_data<=pix_in, lp_en=1, load_cnt++.
  - Cycles without valid: lp_en=0 and lp_data holds.
  - Acceptance of pixel FRAME-1 -> SETTLE; pix_in_ready drops in the same edge, so at most FRAME pixels are accepted.
- SETTLE: lp_en=0, lp_en_proc=0, pix_in_ready=0.
  - Counts SETTLE_CYCLES cycles -> PROC.
- PROC: lp_en_proc=1 for exactly FRAME consecutive cycles, while proc_cnt counts 0..FRAME-1.
  - Each cycle, lp_out is registered into pix_out with pix_out_index=proc_cnt and pix_out_valid=1.
  - Output latency is one cycle after the lp_en_proc cycle.
  - No backpressure: the sink must accept one pixel per cycle.
  - After proc_cnt=FRAME-1 -> DONE.
- DONE: lp_en_proc=0.
  - The last pix_out_valid (index FRAME-1) and done=1 occur in the same cycle.
  - DONE -> IDLE; busy=0 from the following cycle.
- Counter wrap: counters never exceed FRAME-1. Both clear on entry to CLR.
- Simultaneous start and rst: rst wins.
- pix_in_valid outside LOAD: ignored (pix_in_ready=0).

Optional Feature:
- Macro: LP_CTRL_TIMEOUT_EN.
- When defined:
  - A stall counter runs in LOAD. It clears on every accepted pixel and increments otherwise.
  - When it reaches TIMEOUT_CYCLES: err=1 for one cycle, lp_rst=1 for that cycle, and the state returns to IDLE without a done pulse.
  - err resets to 0.
- When undefined: there is no err port and no stall counter, and LOAD waits indefinitely.

Test Plan:
All scenarios use DEPTH=4, WIDTH=3 (FRAME=12) and SETTLE_CYCLES=2.
- Nominal frame: pulse start, stream pixels 0..11 with continuous valid and a pass-through filter model -> lp_rst high 1 cycle, lp_en high 12 cycles, 2 settle cycles, lp_en_proc high 12 cycles, pix_out 0..11 with index 0..11, done coincident with index 11, busy low afterwards.
- Gapped input: valid toggles 1/0 -> lp_en pulses only on accepted pixels, load takes 23 cycles, output identical to nominal.
- Over-supply: source holds valid after pixel 11 -> pix_in_ready=0 after the 12th accept, 13th pixel not loaded.
- Reset mid-PROC: assert rst at proc_cnt=5 -> next cycle all outputs at reset values and state IDLE; a new start then completes a full 12-pixel frame.
- Start while busy: pulse start during SETTLE -> no effect, exactly one done.
- With LP_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=8: stop valid after 5 pixels -> err pulse 8 cycles later, return to IDLE, done never asserted.
